board_controller: RTL and testbench

- Owns the 3x3 game board and sequences each placement: validate, write, eliminate the oldest mark, check for a win, then update gameend.
- Drives the cell bus a0..a8 and gameend consumed by the input/turn logic.
- Accepts placement strobes from the input stage.
- Each player keeps at most MAX_MARKS marks on the board. Placing one more evicts that player's oldest mark in the same cycle.

---
 rtl/board_controller.sv | 208 ++++++++++++++++++++
 tb/tb_board_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/board_controller.sv
// Owns the 3x3 board. Each placement is validated, written (evicting the mover's oldest mark),
// then checked for a line or a draw on the following cycle.
module board_controller #(
  parameter int MAX_MARKS = 3,
  parameter int MAX_MOVES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       place_valid,
  input  logic [3:0] place_loc,
  input  logic [1:0] place_mark,
  output logic       place_ack,
  output logic       place_err,
  output logic       busy,
  output logic [1:0] a0,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [3:0] next_elim_x,
  output logic [3:0] next_elim_o,
  output logic [5:0] move_count,
  output logic [1:0] gameend
);

  localparam logic [2:0] MAXC  = 3'(MAX_MARKS);
  localparam logic [5:0] MAXMV = 6'(MAX_MOVES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CHECK = 2'd2,
    S_END   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [8:0][1:0]        board_q, board_d;
  // Per-player history ring: index 0 = X, 1 = O.
  logic [1:0][3:0][3:0]   slot_q, slot_d;
  logic [1:0][1:0]        head_q, head_d;
  logic [1:0][2:0]        cnt_q, cnt_d;
  logic [1:0][3:0]        elim_q, elim_d;
  logic [1:0]             mover_q, mover_d;
  logic [5:0]             mc_q, mc_d;
  logic [1:0]             ge_q, ge_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;

  logic                   plyr_s;
  logic [1:0]             target_s;
  logic                   legal_s;
  logic [1:0]             tail_s;

  function automatic logic [1:0] wrap_add(input logic [1:0] ptr, input logic [2:0] n);
    logic [2:0] s;
    s = {1'b0, ptr} + n;
    if (s >= MAXC) begin
      s = s - MAXC;
    end else begin
      s = s;
    end
    return s[1:0];
  endfunction

  function automatic logic line_done(input logic [8:0][1:0] b, input logic [1:0] m);
    return (b[0] == m && b[1] == m && b[2] == m) ||
           (b[3] == m && b[4] == m && b[5] == m) ||
           (b[6] == m && b[7] == m && b[8] == m) ||
           (b[0] == m && b[3] == m && b[6] == m) ||
           (b[1] == m && b[4] == m && b[7] == m) ||
           (b[2] == m && b[5] == m && b[8] == m) ||
           (b[0] == m && b[4] == m && b[8] == m) ||
           (b[2] == m && b[4] == m && b[6] == m);
  endfunction

  // Next-state, board/queue update and pulse generation.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    slot_d   = slot_q;
    head_d   = head_q;
    cnt_d    = cnt_q;
    mover_d  = mover_q;
    mc_d     = mc_q;
    ge_d     = ge_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    elim_d   = elim_q;
    plyr_s   = (place_mark == 2'b01);
    target_s = (place_loc <= 4'd8) ? board_q[place_loc] : 2'b11;
    legal_s  = (place_loc <= 4'd8) && (place_mark == 2'b10 || place_mark == 2'b01) &&
               (target_s == 2'b00);
    tail_s   = wrap_add(head_q[plyr_s], cnt_q[plyr_s]);

    case (state_q)
      S_IDLE, S_END: begin
        err_d = place_valid;
        if (start) begin
          board_d = '0;
          head_d  = '0;
          cnt_d   = '0;
          mc_d    = 6'd0;
          ge_d    = 2'b00;
          state_d = S_PLAY;
        end else begin
          state_d = state_q;
        end
      end
      S_PLAY: begin
        if (place_valid && legal_s) begin
          // When full, the tail slot coincides with the head: overwrite it and advance.
          if (cnt_q[plyr_s] == MAXC) begin
            board_d[slot_q[plyr_s][head_q[plyr_s]]] = 2'b00;
            slot_d[plyr_s][head_q[plyr_s]]          = place_loc;
            head_d[plyr_s]                          = wrap_add(head_q[plyr_s], 3'd1);
          end else begin
            slot_d[plyr_s][tail_s] = place_loc;
            cnt_d[plyr_s]          = cnt_q[plyr_s] + 3'd1;
          end
          board_d[place_loc] = place_mark;
          mover_d            = place_mark;
          mc_d               = (mc_q == 6'd63) ? mc_q : mc_q + 6'd1;
          ack_d              = 1'b1;
          state_d            = S_CHECK;
        end else if (place_valid) begin
          err_d = 1'b1;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_CHECK: begin
        err_d = place_valid;
        if (line_done(board_q, mover_q)) begin
          ge_d    = mover_q;
          state_d = S_END;
        end else if (mc_q == MAXMV) begin
          ge_d    = 2'b11;
          state_d = S_END;
        end else begin
          state_d = S_PLAY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    for (int p = 0; p < 2; p++) begin
      if (cnt_d[p] == MAXC) begin
        elim_d[p] = slot_d[p][head_d[p]];
      end else begin
        elim_d[p] = 4'd9;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      board_q <= '0;
      slot_q  <= '0;
      head_q  <= '0;
      cnt_q   <= '0;
      elim_q  <= {4'd9, 4'd9};
      mover_q <= 2'b00;
      mc_q    <= 6'd0;
      ge_q    <= 2'b00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      slot_q  <= slot_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      elim_q  <= elim_d;
      mover_q <= mover_d;
      mc_q    <= mc_d;
      ge_q    <= ge_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign place_ack   = ack_q;
  assign place_err   = err_q;
  assign busy        = (state_q == S_CHECK);
  assign a0          = board_q[0];
  assign a1          = board_q[1];
  assign a2          = board_q[2];
  assign a3          = board_q[3];
  assign a4          = board_q[4];
  assign a5          = board_q[5];
  assign a6          = board_q[6];
  assign a7          = board_q[7];
  assign a8          = board_q[8];
  assign next_elim_x = elim_q[0];
  assign next_elim_o = elim_q[1];
  assign move_count  = mc_q;
  assign gameend     = ge_q;

endmodule

// File: tb/tb_board_controller.sv
// Directed and random placements checked every cycle against a queue-based game model.
module tb_board_controller;

  localparam int MAXM  = 3;
  localparam int MAXMV = 30;
  localparam logic [1:0] MX = 2'b10;
  localparam logic [1:0] MO = 2'b01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       place_valid = 1'b0;
  logic [3:0] place_loc = 4'd0;
  logic [1:0] place_mark = 2'b00;
  logic       place_ack, place_err, busy;
  logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [3:0] next_elim_x, next_elim_o;
  logic [5:0] move_count;
  logic [1:0] gameend;

  board_controller #(.MAX_MARKS(MAXM), .MAX_MOVES(MAXMV)) dut (
    .clk(clk), .rst(rst), .start(start), .place_valid(place_valid),
    .place_loc(place_loc), .place_mark(place_mark),
    .place_ack(place_ack), .place_err(place_err), .busy(busy),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
    .next_elim_x(next_elim_x), .next_elim_o(next_elim_o),
    .move_count(move_count), .gameend(gameend)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Game model: phase 0 idle, 1 play, 2 check, 3 end.
  int         mphase;
  logic [1:0] mb [9];
  int         qx [$];
  int         qo [$];
  int         mmc;
  logic [1:0] mge, mmover;
  logic       mack, merr;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mwin(input logic [1:0] m);
    for (int l = 0; l < 8; l++) begin
      if (mb[lines[l][0]] == m && mb[lines[l][1]] == m && mb[lines[l][2]] == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    mphase = 0;
    for (int i = 0; i < 9; i++) mb[i] = 2'b00;
    qx.delete();
    qo.delete();
    mmc = 0;
    mge = 2'b00;
    mmover = 2'b00;
    mack = 1'b0;
    merr = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit pv, input int loc, input logic [1:0] mark);
    mack = 1'b0;
    merr = 1'b0;
    if (mphase == 0 || mphase == 3) begin
      if (pv) merr = 1'b1;
      if (s) begin
        for (int i = 0; i < 9; i++) mb[i] = 2'b00;
        qx.delete();
        qo.delete();
        mmc = 0;
        mge = 2'b00;
        mphase = 1;
      end
    end else if (mphase == 1) begin
      if (pv) begin
        if (loc <= 8 && (mark == MX || mark == MO) && mb[loc] == 2'b00) begin
          mb[loc] = mark;
          mmover = mark;
          if (mark == MX) begin
            qx.push_back(loc);
            if (qx.size() > MAXM) mb[qx.pop_front()] = 2'b00;
          end else begin
            qo.push_back(loc);
            if (qo.size() > MAXM) mb[qo.pop_front()] = 2'b00;
          end
          if (mmc < 63) mmc++;
          mack = 1'b1;
          mphase = 2;
        end else begin
          merr = 1'b1;
        end
      end
    end else begin
      if (pv) merr = 1'b1;
      if (mwin(mmover)) begin
        mge = mmover;
        mphase = 3;
      end else if (mmc == MAXMV) begin
        mge = 2'b11;
        mphase = 3;
      end else begin
        mphase = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [1:0] cells [9];
    int ex, eo;
    cells = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    for (int i = 0; i < 9; i++) chk($sformatf("a%0d", i), {6'd0, cells[i]}, {6'd0, mb[i]});
    ex = (qx.size() == MAXM) ? qx[0] : 9;
    eo = (qo.size() == MAXM) ? qo[0] : 9;
    chk("place_ack", {7'd0, place_ack}, {7'd0, mack});
    chk("place_err", {7'd0, place_err}, {7'd0, merr});
    chk("busy", {7'd0, busy}, {7'd0, (mphase == 2)});
    chk("move_count", {2'd0, move_count}, 8'(mmc));
    chk("gameend", {6'd0, gameend}, {6'd0, mge});
    chk("next_elim_x", {4'd0, next_elim_x}, 8'(ex));
    chk("next_elim_o", {4'd0, next_elim_o}, 8'(eo));
  endtask

  task automatic step(input bit s, input bit pv, input int loc, input logic [1:0] mark);
    start = s;
    place_valid = pv;
    place_loc = 4'(loc);
    place_mark = mark;
    @(posedge clk);
    model_edge(s, pv, loc, mark);
    #1;
    check_all();
    start = 1'b0;
    place_valid = 1'b0;
  endtask

  // Place a mark and let the CHECK cycle complete.
  task automatic play(input int loc, input logic [1:0] mark);
    step(1'b0, 1'b1, loc, mark);
    step(1'b0, 1'b0, 0, 2'b00);
  endtask

  int xcyc [4] = '{0, 1, 5, 6};
  int ocyc [4] = '{2, 3, 4, 8};

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    // First placement, then illegal requests.
    step(1'b1, 1'b0, 0, 2'b00);
    play(4, MX);
    step(1'b0, 1'b1, 4, MO);
    step(1'b0, 1'b1, 9, MX);
    step(1'b0, 1'b1, 2, 2'b11);
    step(1'b0, 1'b1, 2, 2'b00);

    // X completes the top row, with X@4 evicted on the last move.
    play(0, MX); play(3, MO); play(1, MX); play(5, MO); play(2, MX);
    step(1'b0, 1'b1, 6, MO);
    step(1'b0, 1'b0, 0, 2'b00);
    step(1'b1, 1'b1, 6, MO);

    // Eviction without a win.
    play(0, MX); play(8, MO); play(1, MX); play(7, MO); play(5, MX); play(2, MO);
    step(1'b1, 1'b1, 3, MX);
    step(1'b0, 1'b1, 3, MX);
    step(1'b0, 1'b1, 6, MO);

    // Asynchronous reset while CHECK is pending.
    step(1'b0, 1'b0, 0, 2'b00);
    step(1'b0, 1'b1, 4, MO);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step(1'b0, 1'b1, 0, MX);

    // Alternating non-winning cycles until the move limit declares a draw.
    step(1'b1, 1'b0, 0, 2'b00);
    for (int i = 0; i < MAXMV / 2; i++) begin
      play(xcyc[i % 4], MX);
      play(ocyc[i % 4], MO);
    end
    step(1'b0, 1'b1, 0, MX);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] mk;
      r = $urandom_range(0, 9);
      mk = (r < 4) ? MX : (r < 8) ? MO : (r == 8) ? 2'b00 : 2'b11;
      step(($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 10), mk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
